wb_regfile: RTL and testbench

Write-back stage and architectural register file of the five-stage pipeline. It consumes the MEM/WB pipeline-register outputs: RegWrite, MemtoReg, memory read data, ALU result and destination register. It selects the write-back value and commits it to a 32×32 register file on the clock edge. It serves the two ID-stage read ports with write-before-read bypass and keeps a retired-write counter and a debug read port for benches.

---
 rtl/wb_regfile.sv | 64 ++++++
 tb/tb_wb_regfile.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back select, 32x32 architectural register file with write-before-read
// bypass on both ID read ports, a retired-write counter and a raw debug port.
module wb_regfile #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             RegWrite_i,
    input  logic             MemtoReg_i,
    input  logic [WIDTH-1:0] ReadData_i,
    input  logic [WIDTH-1:0] ALUResult_i,
    input  logic [4:0]       RdAddr_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    output logic [WIDTH-1:0] RS1data_o,
    output logic [WIDTH-1:0] RS2data_o,
    output logic [WIDTH-1:0] WBdata_o,
    output logic             WBvalid_o,
    output logic [31:0]      commit_cnt_o,
    input  logic [4:0]       dbg_addr_i,
    output logic [WIDTH-1:0] dbg_data_o
);

    localparam int unsigned CNT_W = 32;

    logic [WIDTH-1:0] regs [DEPTH];

    assign WBdata_o  = MemtoReg_i ? ReadData_i : ALUResult_i;
    // RegWrite_i low forces this to 0 even when RdAddr_i is unknown.
    assign WBvalid_o = RegWrite_i && (RdAddr_i != 5'd0);

    // Commit and retired-write count; r0 is never written since WBvalid_o excludes it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            commit_cnt_o <= '0;
        end else if (WBvalid_o) begin
            regs[RdAddr_i] <= WBdata_o;
            commit_cnt_o   <= commit_cnt_o + CNT_W'(1);
        end
    end

    // Same-cycle write-before-read bypass removes the WB->ID hazard.
    always_comb begin
        RS1data_o = '0;
        RS2data_o = '0;
        if (WBvalid_o && (RS1addr_i == RdAddr_i)) begin
            RS1data_o = WBdata_o;
        end else if (RS1addr_i != 5'd0) begin
            RS1data_o = regs[RS1addr_i];
        end
        if (WBvalid_o && (RS2addr_i == RdAddr_i)) begin
            RS2data_o = WBdata_o;
        end else if (RS2addr_i != 5'd0) begin
            RS2data_o = regs[RS2addr_i];
        end
    end

    assign dbg_data_o = (dbg_addr_i == 5'd0) ? '0 : regs[dbg_addr_i];

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile: reset, commits, bypass,
// r0 protection, write-enable gating and a RegWrite/MemtoReg toggle sequence.
module tb_wb_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i;
    logic        MemtoReg_i;
    logic [31:0] ReadData_i;
    logic [31:0] ALUResult_i;
    logic [4:0]  RdAddr_i;
    logic [4:0]  RS1addr_i;
    logic [4:0]  RS2addr_i;
    logic [31:0] RS1data_o;
    logic [31:0] RS2data_o;
    logic [31:0] WBdata_o;
    logic        WBvalid_o;
    logic [31:0] commit_cnt_o;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_data_o;

    int checks   = 0;
    int failures = 0;

    wb_regfile #(.DEPTH(32), .WIDTH(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .RegWrite_i   (RegWrite_i),
        .MemtoReg_i   (MemtoReg_i),
        .ReadData_i   (ReadData_i),
        .ALUResult_i  (ALUResult_i),
        .RdAddr_i     (RdAddr_i),
        .RS1addr_i    (RS1addr_i),
        .RS2addr_i    (RS2addr_i),
        .RS1data_o    (RS1data_o),
        .RS2data_o    (RS2data_o),
        .WBdata_o     (WBdata_o),
        .WBvalid_o    (WBvalid_o),
        .commit_cnt_o (commit_cnt_o),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_data_o   (dbg_data_o)
    );

    always #10 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_dbg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        dbg_addr_i = addr;
        #1;
        check(tag, dbg_data_o, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic we, input logic m2r, input logic [31:0] rd_data,
                         input logic [31:0] alu, input logic [4:0] rd);
        RegWrite_i  = we;
        MemtoReg_i  = m2r;
        ReadData_i  = rd_data;
        ALUResult_i = alu;
        RdAddr_i    = rd;
    endtask

    logic        tg_we  [5];
    logic        tg_m2r [5];
    logic [31:0] tg_exp [5];

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        RS1addr_i  = 5'd0;
        RS2addr_i  = 5'd0;
        dbg_addr_i = 5'd0;
        step();
        check("rst_cnt", commit_cnt_o, 32'h0);
        check_dbg("rst_dbg5", 5'd5, 32'h0);

        // Write-back mux still follows inputs during reset; an edge commits nothing.
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0ABC, 5'd5);
        #1;
        check("rst_wbdata", WBdata_o, 32'h0000_0ABC);
        check("rst_wbvalid", 32'(WBvalid_o), 32'h1);
        step();
        check("rst_edge_cnt", commit_cnt_o, 32'h0);
        check_dbg("rst_edge_dbg5", 5'd5, 32'h0);

        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0000_1234, 5'd5);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        check_dbg("r5_written", 5'd5, 32'h0000_1234);
        check("r5_cnt", commit_cnt_o, 32'h1);

        // Asynchronous reset mid-cycle.
        rst_i     = 1'b1;
        RS1addr_i = 5'd5;
        #1;
        check("async_cnt", commit_cnt_o, 32'h0);
        check_dbg("async_dbg5", 5'd5, 32'h0);
        check("async_rs1", RS1data_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Basic writes: ALU then memory data into r3.
        drive(1'b1, 1'b0, 32'hCAFE_0000, 32'h7FFF_FFFF, 5'd3);
        step();
        check_dbg("r3_alu", 5'd3, 32'h7FFF_FFFF);
        check("r3_alu_cnt", commit_cnt_o, 32'h1);
        drive(1'b1, 1'b1, 32'h0000_0001, 32'h9999_9999, 5'd3);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        check_dbg("r3_mem", 5'd3, 32'h0000_0001);
        check("r3_mem_cnt", commit_cnt_o, 32'h2);
        RS2addr_i = 5'd3;
        #1;
        check("rs2_plain", RS2data_o, 32'h0000_0001);

        // Bypass on both ports at once.
        drive(1'b1, 1'b0, 32'h0, 32'h1111_1111, 5'd16);
        step();
        @(negedge clk_i);
        RS1addr_i = 5'd16;
        RS2addr_i = 5'd16;
        drive(1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 5'd16);
        #1;
        check("byp_rs1", RS1data_o, 32'hDEAD_BEEF);
        check("byp_rs2", RS2data_o, 32'hDEAD_BEEF);
        check_dbg("byp_dbg_old", 5'd16, 32'h1111_1111);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd16);
        #1;
        check("post_rs1", RS1data_o, 32'hDEAD_BEEF);
        check("post_rs2", RS2data_o, 32'hDEAD_BEEF);
        check("post_cnt", commit_cnt_o, 32'h4);

        // r0 protection.
        @(negedge clk_i);
        RS1addr_i = 5'd0;
        drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
        #1;
        check("r0_rs1", RS1data_o, 32'h0);
        check("r0_wbvalid", 32'(WBvalid_o), 32'h0);
        check("r0_wbdata", WBdata_o, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        check_dbg("r0_dbg", 5'd0, 32'h0);
        check("r0_cnt", commit_cnt_o, 32'h4);

        // Write enable low: no bypass, no commit.
        @(negedge clk_i);
        RS1addr_i = 5'd7;
        drive(1'b0, 1'b0, 32'h0, 32'h0000_0055, 5'd7);
        #1;
        check("we0_rs1", RS1data_o, 32'h0);
        check("we0_wbvalid", 32'(WBvalid_o), 32'h0);
        step();
        check_dbg("we0_dbg7", 5'd7, 32'h0);
        check("we0_cnt", commit_cnt_o, 32'h4);

        // RegWrite low blocks the write even with unknown data and address.
        @(negedge clk_i);
        drive(1'b0, 1'bx, 32'hx, 32'hx, 5'bx);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        check_dbg("x_dbg3", 5'd3, 32'h0000_0001);
        check("x_cnt", commit_cnt_o, 32'h4);

        // Toggle sequence over r16..r20.
        tg_we[0] = 1'b1; tg_m2r[0] = 1'b0; tg_exp[0] = 32'h0000_00A0;
        tg_we[1] = 1'b0; tg_m2r[1] = 1'b1; tg_exp[1] = 32'h0000_0000;
        tg_we[2] = 1'b1; tg_m2r[2] = 1'b1; tg_exp[2] = 32'h0000_00B2;
        tg_we[3] = 1'b0; tg_m2r[3] = 1'b0; tg_exp[3] = 32'h0000_0000;
        tg_we[4] = 1'b1; tg_m2r[4] = 1'b1; tg_exp[4] = 32'h0000_00B4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            drive(tg_we[i], tg_m2r[i], 32'h0000_00B0 + 32'(i),
                  32'h0000_00A0 + 32'(i), 5'(16 + i));
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            check_dbg($sformatf("tg_r%0d", 16 + i), 5'(16 + i), tg_exp[i]);
        end
        check("tg_cnt", commit_cnt_o, 32'h7);

        // Reset asserted across a write edge: the write is lost.
        @(negedge clk_i);
        drive(1'b1, 1'b0, 32'h0, 32'h0000_0099, 5'd9);
        rst_i = 1'b1;
        step();
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        check_dbg("rstw_dbg9", 5'd9, 32'h0);
        check("rstw_cnt", commit_cnt_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
